// File: rtl/ew_fifo_reader_pkg.sv
// Shared tracker parameters, descriptor layout and reader FSM states for the
// event-window FIFO reader.
package ew_fifo_reader_pkg;

    localparam int DIGI_BITS       = 16;
    localparam int EVENT_SIZE_BITS = 8;
    localparam int SPILL_TAG_BITS  = 6;

    // Field order places the tag in the LSBs so a zero-extended descriptor is the header beat.
    typedef struct packed {
        logic                       ovfl;
        logic [EVENT_SIZE_BITS-1:0] size;
        logic [SPILL_TAG_BITS-1:0]  tag;
    } ew_desc_t;

    localparam int DESC_BITS = $bits(ew_desc_t);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA
    } rd_state_e;

    function automatic logic [DIGI_BITS-1:0] make_header(input ew_desc_t d);
        return DIGI_BITS'(d);
    endfunction

endpackage

// File: rtl/ew_desc_fifo.sv
// First-word-fall-through queue of event descriptors; a push into a full
// queue is still taken when a pop happens in the same cycle.
module ew_desc_fifo
    import ew_fifo_reader_pkg::*;
#(
    parameter int DESC_DEPTH = 4
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     push_i,
    input  ew_desc_t wdata_i,
    input  logic     pop_i,
    output ew_desc_t rdata_o,
    output logic     empty_o,
    output logic     full_o
);

    localparam int AW = $clog2(DESC_DEPTH);

    ew_desc_t        mem_q [DESC_DEPTH];
    logic [AW-1:0]   wptr_q;
    logic [AW-1:0]   rptr_q;
    logic [AW:0]     cnt_q;
    logic            do_push;
    logic            do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DESC_DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rptr_q];

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (do_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/ew_fifo_reader.sv
// Drains the event-window data FIFO as header-plus-payload events, one per
// queued descriptor, with a 2-entry skid so the ready/valid output never loses beats.
module ew_fifo_reader
    import ew_fifo_reader_pkg::*;
#(
    parameter int DESC_DEPTH = 4
) (
    input  logic                       serdesclk,
    input  logic                       serdes_reset,
    input  logic                       ew_done,
    input  logic                       ew_ovfl,
    input  logic [EVENT_SIZE_BITS-1:0] ew_size,
    input  logic [SPILL_TAG_BITS-1:0]  ew_tag,
    input  logic                       fifo_empty,
    input  logic [DIGI_BITS-1:0]       fifo_rdata,
    output logic                       fifo_re,
    output logic                       evt_valid,
    input  logic                       evt_ready,
    output logic [DIGI_BITS-1:0]       evt_data,
    output logic                       evt_first,
    output logic                       evt_last,
    output logic                       desc_drop,
    output logic [15:0]                evt_count
);

    rd_state_e                  state_q, state_d;
    ew_desc_t                   cur_q, cur_d;
    ew_desc_t                   desc_wdata, desc_rdata;
    logic                       desc_empty, desc_full, desc_pop;
    logic [EVENT_SIZE_BITS-1:0] req_q, req_d;
    logic [EVENT_SIZE_BITS-1:0] left_q, left_d;
    logic [DIGI_BITS-1:0]       skid0_q, skid1_q;
    logic [1:0]                 skid_cnt_q;
    logic                       inflight_q;
    logic                       drop_q;
    logic [15:0]                count_q;
    logic                       beat_pop;
    logic                       evt_end;
    logic [1:0]                 held;

    assign desc_wdata = '{ovfl: ew_ovfl, size: ew_size, tag: ew_tag};
    assign desc_drop  = drop_q;
    assign evt_count  = count_q;

    ew_desc_fifo #(
        .DESC_DEPTH(DESC_DEPTH)
    ) u_desc_fifo (
        .clk_i   (serdesclk),
        .rst_i   (serdes_reset),
        .push_i  (ew_done),
        .wdata_i (desc_wdata),
        .pop_i   (desc_pop),
        .rdata_o (desc_rdata),
        .empty_o (desc_empty),
        .full_o  (desc_full)
    );

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        req_d     = req_q;
        left_d    = left_q;
        desc_pop  = 1'b0;
        evt_valid = 1'b0;
        evt_data  = '0;
        evt_first = 1'b0;
        evt_last  = 1'b0;
        evt_end   = 1'b0;
        beat_pop  = 1'b0;

        case (state_q)
            ST_IDLE: begin
            end
            ST_HDR: begin
                evt_valid = 1'b1;
                evt_data  = make_header(cur_q);
                evt_first = 1'b1;
                evt_last  = (cur_q.size == '0);
                if (evt_ready) begin
                    if (cur_q.size == '0) begin
                        evt_end = 1'b1;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                // With the skid empty, a beat arriving from the FIFO is forwarded directly.
                evt_valid = (skid_cnt_q != 2'd0) || inflight_q;
                evt_data  = (skid_cnt_q != 2'd0) ? skid0_q : fifo_rdata;
                evt_last  = (left_q == EVENT_SIZE_BITS'(1));
                if (evt_valid && evt_ready) begin
                    beat_pop = 1'b1;
                    left_d   = left_q - 1'b1;
                    evt_end  = evt_last;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Held counts only beats that remain in the skid after this cycle's pop.
        held    = skid_cnt_q - {1'b0, beat_pop && (skid_cnt_q != 2'd0)};
        fifo_re = (state_q != ST_IDLE) && !fifo_empty && (req_q != '0) &&
                  ((held + {1'b0, inflight_q}) < 2'd2);
        if (fifo_re) begin
            req_d = req_q - 1'b1;
        end

        if ((state_q == ST_IDLE) || evt_end) begin
            if (!desc_empty) begin
                desc_pop = 1'b1;
                cur_d    = desc_rdata;
                req_d    = desc_rdata.size;
                left_d   = desc_rdata.size;
                state_d  = ST_HDR;
            end else begin
                state_d  = ST_IDLE;
            end
        end
    end

    always_ff @(posedge serdesclk) begin
        if (serdes_reset) begin
            state_q    <= ST_IDLE;
            cur_q      <= '0;
            req_q      <= '0;
            left_q     <= '0;
            inflight_q <= 1'b0;
            drop_q     <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            req_q      <= req_d;
            left_q     <= left_d;
            inflight_q <= fifo_re;
            if (ew_done && desc_full && !desc_pop) begin
                drop_q <= 1'b1;
            end
            if (evt_valid && evt_ready && evt_last) begin
                count_q <= count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge serdesclk) begin
        if (serdes_reset) begin
            skid_cnt_q <= 2'd0;
            skid0_q    <= '0;
            skid1_q    <= '0;
        end else begin
            case ({inflight_q, beat_pop})
                2'b10: begin
                    if (skid_cnt_q == 2'd0) begin
                        skid0_q <= fifo_rdata;
                    end else begin
                        skid1_q <= fifo_rdata;
                    end
                    skid_cnt_q <= skid_cnt_q + 2'd1;
                end
                2'b01: begin
                    skid0_q    <= skid1_q;
                    skid_cnt_q <= skid_cnt_q - 2'd1;
                end
                2'b11: begin
                    if (skid_cnt_q == 2'd1) begin
                        skid0_q <= fifo_rdata;
                    end else if (skid_cnt_q == 2'd2) begin
                        skid0_q <= skid1_q;
                        skid1_q <= fifo_rdata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ew_fifo_reader.sv
// Directed bench for ew_fifo_reader: behavioural data FIFO, accepted-beat
// monitor and one task per scenario with hand-computed expectations.
module tb_ew_fifo_reader;
    import ew_fifo_reader_pkg::*;

    typedef struct {
        logic [DIGI_BITS-1:0] data;
        logic                 first;
        logic                 last;
        int                   cyc;
    } beat_t;

    logic                       serdesclk = 1'b0;
    logic                       serdes_reset;
    logic                       ew_done;
    logic                       ew_ovfl;
    logic [EVENT_SIZE_BITS-1:0] ew_size;
    logic [SPILL_TAG_BITS-1:0]  ew_tag;
    logic                       fifo_empty = 1'b1;
    logic [DIGI_BITS-1:0]       fifo_rdata = '0;
    logic                       fifo_re;
    logic                       evt_valid;
    logic                       evt_ready;
    logic [DIGI_BITS-1:0]       evt_data;
    logic                       evt_first;
    logic                       evt_last;
    logic                       desc_drop;
    logic [15:0]                evt_count;

    logic [DIGI_BITS-1:0] fq [$];
    beat_t                cap [$];
    beat_t                mb;
    int                   cyc = 0;
    int                   re_cnt = 0;
    int                   fsz;
    int                   checks = 0;
    int                   passed = 0;

    ew_fifo_reader #(
        .DESC_DEPTH(4)
    ) dut (
        .serdesclk    (serdesclk),
        .serdes_reset (serdes_reset),
        .ew_done      (ew_done),
        .ew_ovfl      (ew_ovfl),
        .ew_size      (ew_size),
        .ew_tag       (ew_tag),
        .fifo_empty   (fifo_empty),
        .fifo_rdata   (fifo_rdata),
        .fifo_re      (fifo_re),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_data     (evt_data),
        .evt_first    (evt_first),
        .evt_last     (evt_last),
        .desc_drop    (desc_drop),
        .evt_count    (evt_count)
    );

    always #5 serdesclk = ~serdesclk;

    // Data FIFO model: read data appears the cycle after fifo_re.
    always @(posedge serdesclk) begin
        cyc++;
        fsz = fq.size();
        if (fifo_re) begin
            re_cnt++;
            if (fsz > 0) begin
                fifo_rdata <= fq.pop_front();
                fsz--;
            end
        end
        fifo_empty <= (fsz == 0);
    end

    // Record every beat that the coming rising edge will accept.
    always @(negedge serdesclk) begin
        #2;
        if (evt_valid && evt_ready) begin
            mb.data  = evt_data;
            mb.first = evt_first;
            mb.last  = evt_last;
            mb.cyc   = cyc;
            cap.push_back(mb);
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge serdesclk);
    endtask

    task automatic push_words(input logic [DIGI_BITS-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            fq.push_back(base + DIGI_BITS'(i));
        end
    endtask

    task automatic send_desc(input logic [SPILL_TAG_BITS-1:0] tag,
                             input logic [EVENT_SIZE_BITS-1:0] size,
                             input logic ovfl);
        @(negedge serdesclk);
        ew_done = 1'b1;
        ew_tag  = tag;
        ew_size = size;
        ew_ovfl = ovfl;
        @(negedge serdesclk);
        ew_done = 1'b0;
    endtask

    task automatic wait_beats(input int n, input int budget);
        int k;
        k = 0;
        while (cap.size() < n && k < budget) begin
            @(negedge serdesclk);
            #3;
            k++;
        end
    endtask

    task automatic test_reset();
        serdes_reset = 1'b1;
        evt_ready    = 1'b0;
        ew_done      = 1'b0;
        ew_ovfl      = 1'b0;
        ew_size      = '0;
        ew_tag       = '0;
        tick(3);
        #1;
        checks++; if (evt_valid !== 1'b0) $display("[TB] FAIL reset_valid got %b want 0", evt_valid); else passed++;
        checks++; if (evt_first !== 1'b0) $display("[TB] FAIL reset_first got %b want 0", evt_first); else passed++;
        checks++; if (evt_last !== 1'b0) $display("[TB] FAIL reset_last got %b want 0", evt_last); else passed++;
        checks++; if (evt_data !== 16'h0000) $display("[TB] FAIL reset_data got %h want 0000", evt_data); else passed++;
        checks++; if (fifo_re !== 1'b0) $display("[TB] FAIL reset_fifo_re got %b want 0", fifo_re); else passed++;
        checks++; if (desc_drop !== 1'b0) $display("[TB] FAIL reset_drop got %b want 0", desc_drop); else passed++;
        checks++; if (evt_count !== 16'd0) $display("[TB] FAIL reset_count got %0d want 0", evt_count); else passed++;
        @(negedge serdesclk);
        serdes_reset = 1'b0;
        tick(2);
    endtask

    task automatic test_basic();
        logic [DIGI_BITS+1:0] exp_b [4];
        int r0;
        exp_b[0] = {2'b10, 16'h00C5};
        exp_b[1] = {2'b00, 16'hA000};
        exp_b[2] = {2'b00, 16'hA001};
        exp_b[3] = {2'b01, 16'hA002};
        cap.delete();
        evt_ready = 1'b1;
        r0 = re_cnt;
        push_words(16'hA000, 3);
        tick(2);
        send_desc(6'd5, 8'd3, 1'b0);
        wait_beats(4, 40);
        tick(3);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= cap.size()) $display("[TB] FAIL basic_beat%0d got none want %h", i, exp_b[i]);
            else if ({cap[i].first, cap[i].last, cap[i].data} !== exp_b[i])
                $display("[TB] FAIL basic_beat%0d got %h want %h", i, {cap[i].first, cap[i].last, cap[i].data}, exp_b[i]);
            else passed++;
        end
        checks++; if (cap.size() != 4) $display("[TB] FAIL basic_beats got %0d want 4", cap.size()); else passed++;
        checks++; if (re_cnt - r0 != 3) $display("[TB] FAIL basic_reads got %0d want 3", re_cnt - r0); else passed++;
        checks++; if (evt_count !== 16'd1) $display("[TB] FAIL basic_count got %0d want 1", evt_count); else passed++;
    endtask

    task automatic test_zero_size();
        int r0;
        cap.delete();
        r0 = re_cnt;
        send_desc(6'd9, 8'd0, 1'b0);
        wait_beats(1, 30);
        tick(3);
        checks++;
        if (cap.size() < 1) $display("[TB] FAIL zero_beat got none want 30009");
        else if ({cap[0].first, cap[0].last, cap[0].data} !== {2'b11, 16'h0009})
            $display("[TB] FAIL zero_beat got %h want 30009", {cap[0].first, cap[0].last, cap[0].data});
        else passed++;
        checks++; if (cap.size() != 1) $display("[TB] FAIL zero_beats got %0d want 1", cap.size()); else passed++;
        checks++; if (re_cnt != r0) $display("[TB] FAIL zero_reads got %0d want 0", re_cnt - r0); else passed++;
        checks++; if (evt_count !== 16'd2) $display("[TB] FAIL zero_count got %0d want 2", evt_count); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [DIGI_BITS+1:0] exp_b [5];
        int gaps;
        exp_b[0] = {2'b10, 16'h4081};
        exp_b[1] = {2'b00, 16'hB000};
        exp_b[2] = {2'b01, 16'hB001};
        exp_b[3] = {2'b10, 16'h0042};
        exp_b[4] = {2'b01, 16'hB002};
        cap.delete();
        push_words(16'hB000, 3);
        tick(2);
        @(negedge serdesclk);
        ew_done = 1'b1; ew_tag = 6'd1; ew_size = 8'd2; ew_ovfl = 1'b1;
        @(negedge serdesclk);
        ew_done = 1'b1; ew_tag = 6'd2; ew_size = 8'd1; ew_ovfl = 1'b0;
        @(negedge serdesclk);
        ew_done = 1'b0;
        wait_beats(5, 40);
        tick(3);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (i >= cap.size()) $display("[TB] FAIL b2b_beat%0d got none want %h", i, exp_b[i]);
            else if ({cap[i].first, cap[i].last, cap[i].data} !== exp_b[i])
                $display("[TB] FAIL b2b_beat%0d got %h want %h", i, {cap[i].first, cap[i].last, cap[i].data}, exp_b[i]);
            else passed++;
        end
        gaps = 0;
        for (int i = 1; i < 5 && i < cap.size(); i++) begin
            if (cap[i].cyc != cap[i-1].cyc + 1) gaps++;
        end
        checks++; if (gaps != 0 || cap.size() != 5) $display("[TB] FAIL b2b_bubbles got %0d gaps %0d beats want 0 gaps 5 beats", gaps, cap.size()); else passed++;
        checks++; if (evt_count !== 16'd4) $display("[TB] FAIL b2b_count got %0d want 4", evt_count); else passed++;
    endtask

    task automatic test_stall();
        logic [DIGI_BITS+1:0] exp_b [5];
        logic [DIGI_BITS+1:0] held;
        logic prev_stall;
        int viol;
        int k;
        exp_b[0] = {2'b10, 16'h0103};
        exp_b[1] = {2'b00, 16'hC000};
        exp_b[2] = {2'b00, 16'hC001};
        exp_b[3] = {2'b00, 16'hC002};
        exp_b[4] = {2'b01, 16'hC003};
        cap.delete();
        evt_ready = 1'b0;
        push_words(16'hC000, 4);
        tick(2);
        send_desc(6'd3, 8'd4, 1'b0);
        prev_stall = 1'b0;
        held = '0;
        viol = 0;
        k = 0;
        while (cap.size() < 5 && k < 80) begin
            @(negedge serdesclk);
            if (prev_stall && (evt_valid !== 1'b1 || {evt_first, evt_last, evt_data} !== held)) viol++;
            evt_ready = (k % 2 == 0);
            #1;
            prev_stall = evt_valid && !evt_ready;
            held = {evt_first, evt_last, evt_data};
            k++;
        end
        evt_ready = 1'b1;
        tick(4);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (i >= cap.size()) $display("[TB] FAIL stall_beat%0d got none want %h", i, exp_b[i]);
            else if ({cap[i].first, cap[i].last, cap[i].data} !== exp_b[i])
                $display("[TB] FAIL stall_beat%0d got %h want %h", i, {cap[i].first, cap[i].last, cap[i].data}, exp_b[i]);
            else passed++;
        end
        checks++; if (viol != 0) $display("[TB] FAIL stall_stable got %0d changes want 0", viol); else passed++;
        checks++; if (cap.size() != 5) $display("[TB] FAIL stall_beats got %0d want 5", cap.size()); else passed++;
        checks++; if (evt_count !== 16'd5) $display("[TB] FAIL stall_count got %0d want 5", evt_count); else passed++;
    endtask

    task automatic test_overflow();
        logic [DIGI_BITS+1:0] exp_b [10];
        for (int j = 0; j < 5; j++) begin
            exp_b[2*j]   = {2'b10, 16'h004A + 16'(j)};
            exp_b[2*j+1] = {2'b01, 16'hE000 + 16'(j)};
        end
        cap.delete();
        @(negedge serdesclk);
        evt_ready = 1'b0;
        push_words(16'hE000, 5);
        tick(2);
        // One descriptor moves into the stalled header, four fill the queue.
        for (int j = 0; j < 5; j++) begin
            @(negedge serdesclk);
            ew_done = 1'b1; ew_tag = 6'(10 + j); ew_size = 8'd1; ew_ovfl = 1'b0;
        end
        @(negedge serdesclk);
        ew_done = 1'b0;
        tick(2);
        checks++; if (desc_drop !== 1'b0) $display("[TB] FAIL ovf_drop_early got %b want 0", desc_drop); else passed++;
        send_desc(6'd15, 8'd1, 1'b0);
        checks++; if (desc_drop !== 1'b1) $display("[TB] FAIL ovf_drop got %b want 1", desc_drop); else passed++;
        evt_ready = 1'b1;
        wait_beats(10, 80);
        tick(6);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (i >= cap.size()) $display("[TB] FAIL ovf_beat%0d got none want %h", i, exp_b[i]);
            else if ({cap[i].first, cap[i].last, cap[i].data} !== exp_b[i])
                $display("[TB] FAIL ovf_beat%0d got %h want %h", i, {cap[i].first, cap[i].last, cap[i].data}, exp_b[i]);
            else passed++;
        end
        checks++; if (cap.size() != 10) $display("[TB] FAIL ovf_beats got %0d want 10", cap.size()); else passed++;
        checks++; if (evt_count !== 16'd10) $display("[TB] FAIL ovf_count got %0d want 10", evt_count); else passed++;
        checks++; if (desc_drop !== 1'b1) $display("[TB] FAIL ovf_sticky got %b want 1", desc_drop); else passed++;
    endtask

    task automatic test_reset_mid_event();
        logic [DIGI_BITS+1:0] exp_a [3];
        logic [DIGI_BITS+1:0] exp_b [3];
        int k;
        exp_a[0] = {2'b10, 16'h0104};
        exp_a[1] = {2'b00, 16'hF000};
        exp_a[2] = {2'b00, 16'hF001};
        exp_b[0] = {2'b10, 16'h0087};
        exp_b[1] = {2'b00, 16'h7000};
        exp_b[2] = {2'b01, 16'h7001};
        cap.delete();
        evt_ready = 1'b1;
        push_words(16'hF000, 4);
        tick(2);
        send_desc(6'd4, 8'd4, 1'b0);
        k = 0;
        while (cap.size() < 3 && k < 40) begin
            @(negedge serdesclk);
            k++;
        end
        serdes_reset = 1'b1;
        evt_ready    = 1'b0;
        fq.delete();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= cap.size()) $display("[TB] FAIL mid_beat%0d got none want %h", i, exp_a[i]);
            else if ({cap[i].first, cap[i].last, cap[i].data} !== exp_a[i])
                $display("[TB] FAIL mid_beat%0d got %h want %h", i, {cap[i].first, cap[i].last, cap[i].data}, exp_a[i]);
            else passed++;
        end
        @(negedge serdesclk);
        #1;
        checks++; if (evt_valid !== 1'b0) $display("[TB] FAIL mid_valid got %b want 0", evt_valid); else passed++;
        checks++; if (evt_first !== 1'b0) $display("[TB] FAIL mid_first got %b want 0", evt_first); else passed++;
        checks++; if (evt_last !== 1'b0) $display("[TB] FAIL mid_last got %b want 0", evt_last); else passed++;
        checks++; if (evt_data !== 16'h0000) $display("[TB] FAIL mid_data got %h want 0000", evt_data); else passed++;
        checks++; if (fifo_re !== 1'b0) $display("[TB] FAIL mid_fifo_re got %b want 0", fifo_re); else passed++;
        checks++; if (desc_drop !== 1'b0) $display("[TB] FAIL mid_drop got %b want 0", desc_drop); else passed++;
        checks++; if (evt_count !== 16'd0) $display("[TB] FAIL mid_count got %0d want 0", evt_count); else passed++;
        serdes_reset = 1'b0;
        fq.delete();
        tick(2);
        cap.delete();
        evt_ready = 1'b1;
        push_words(16'h7000, 2);
        tick(2);
        send_desc(6'd7, 8'd2, 1'b0);
        wait_beats(3, 40);
        tick(3);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= cap.size()) $display("[TB] FAIL post_beat%0d got none want %h", i, exp_b[i]);
            else if ({cap[i].first, cap[i].last, cap[i].data} !== exp_b[i])
                $display("[TB] FAIL post_beat%0d got %h want %h", i, {cap[i].first, cap[i].last, cap[i].data}, exp_b[i]);
            else passed++;
        end
        checks++; if (cap.size() != 3) $display("[TB] FAIL post_beats got %0d want 3", cap.size()); else passed++;
        checks++; if (evt_count !== 16'd1) $display("[TB] FAIL post_count got %0d want 1", evt_count); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_size();
        test_back_to_back();
        test_stall();
        test_overflow();
        test_reset_mid_event();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
